duck_flight_ctrl: RTL



---
 rtl/duck_flight_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/duck_flight_ctrl.sv
// duck_flight_ctrl: spawns, flies, drops and escapes the hunt duck on a 1024x768 screen.
module duck_flight_ctrl #(
    parameter int SCREEN_W     = 1024,
    parameter int DUCK_W       = 96,
    parameter int DUCK_H       = 60,
    parameter int GROUND_Y     = 600,
    parameter int STEP_DIV     = 650_000,
    parameter int FLY_SPEED    = 4,
    parameter int FALL_SPEED   = 6,
    parameter int ESCAPE_STEPS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hunt_start,
    input  logic        duck_killed,
    output logic [11:0] duck_xpos,
    output logic [11:0] duck_ypos,
    output logic        duck_dir_left,
    output logic        duck_falling,
    output logic        duck_visible,
    output logic        duck_escaped
);
    localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int FW = $clog2(ESCAPE_STEPS + 1) > 6 ? $clog2(ESCAPE_STEPS + 1) : 6;
    localparam logic [11:0] XMAX = 12'(SCREEN_W - DUCK_W);
    localparam logic [11:0] YGND = 12'(GROUND_Y - DUCK_H);
    localparam logic [11:0] FLY  = 12'(FLY_SPEED);
    localparam logic [11:0] FALL = 12'(FALL_SPEED);

    typedef enum logic [1:0] {IDLE, FLYING, ESCAPING, FALLING} state_t;

    state_t        state_q;
    logic [SW-1:0] sc_q;
    logic [FW-1:0] fcnt_q;
    logic [15:0]   lfsr_q;
    logic [11:0]   x_q, y_q;
    logic          dir_left_q, vdown_q, falling_q, visible_q, escaped_q;
    logic          step, vdown_eff, dir_left_d, vdown_d;
    logic [11:0]   spawn_x, x_d, y_d;

    always_comb begin
        step       = sc_q == SW'(STEP_DIV - 1);
        spawn_x    = {2'b00, lfsr_q[9:0]} > XMAX ? {2'b00, lfsr_q[9:0]} - 12'd128 : {2'b00, lfsr_q[9:0]};
        vdown_eff  = (fcnt_q[5:0] == 6'd0 && fcnt_q != '0) ? lfsr_q[0] : vdown_q;
        // Bounce tests run on the old position so subtraction never underflows
        x_d        = dir_left_q ? (x_q < FLY ? 12'd0 : x_q - FLY) : (x_q > XMAX - FLY ? XMAX : x_q + FLY);
        dir_left_d = dir_left_q ? !(x_q < FLY) : (x_q > XMAX - FLY);
        y_d        = vdown_eff ? (y_q > YGND - FLY ? YGND : y_q + FLY) : (y_q < FLY ? 12'd0 : y_q - FLY);
        vdown_d    = vdown_eff ? !(y_q > YGND - FLY) : (y_q < FLY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sc_q       <= '0;
            fcnt_q     <= '0;
            lfsr_q     <= 16'hACE1;
            x_q        <= '0;
            y_q        <= YGND;
            dir_left_q <= 1'b0;
            vdown_q    <= 1'b0;
            falling_q  <= 1'b0;
            visible_q  <= 1'b0;
            escaped_q  <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            sc_q      <= step ? '0 : sc_q + 1'b1;
            escaped_q <= 1'b0;
            case (state_q)
                IDLE: if (hunt_start) begin
                    state_q    <= FLYING;
                    x_q        <= spawn_x;
                    y_q        <= YGND;
                    dir_left_q <= lfsr_q[15];
                    vdown_q    <= 1'b0;
                    fcnt_q     <= '0;
                    visible_q  <= 1'b1;
                end
                FLYING: if (duck_killed) begin
                    state_q   <= FALLING;
                    falling_q <= 1'b1;
                end else if (step && hunt_start) begin
                    x_q        <= x_d;
                    y_q        <= y_d;
                    dir_left_q <= dir_left_d;
                    vdown_q    <= vdown_d;
                    fcnt_q     <= fcnt_q + 1'b1;
                    if (fcnt_q == FW'(ESCAPE_STEPS - 1)) state_q <= ESCAPING;
                end
                ESCAPING: if (duck_killed) begin
                    state_q   <= FALLING;
                    falling_q <= 1'b1;
                end else if (step) begin
                    if (y_q < FLY) begin
                        state_q   <= IDLE;
                        visible_q <= 1'b0;
                        escaped_q <= 1'b1;
                    end else y_q <= y_q - FLY;
                end
                default: if (step) begin
                    if (y_q >= YGND - FALL) begin
                        state_q   <= IDLE;
                        y_q       <= YGND;
                        falling_q <= 1'b0;
                        visible_q <= 1'b0;
                    end else y_q <= y_q + FALL;
                end
            endcase
        end
    end

    assign duck_xpos     = x_q;
    assign duck_ypos     = y_q;
    assign duck_dir_left = dir_left_q;
    assign duck_falling  = falling_q;
    assign duck_visible  = visible_q;
    assign duck_escaped  = escaped_q;
endmodule
